sb_rx_serializer: RTL

SB_RX_SERIALIZER -- requirements
Module: sb_rx_serializer

---
 rtl/sb_rx_serializer.sv | 111 +++++++++++
 1 files changed

// File: rtl/sb_rx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sb_rx_serializer
// Brief    : Splits a DW-bit switchboard packet into NB = DW/OW beats of OW
//            bits each (beat 0 = LSBs), with valid/ready handshakes on both
//            sides and back-to-back packet issue with no bubble.
// Revision : 1.0 - initial release
// ============================================================================
module sb_rx_serializer #(
  parameter int DW = 416,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic [31:0]   in_dest,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_first,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int NB = DW / OW;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  // Reject widths that do not split into a whole number of beats.
  if ((OW > DW) || ((DW % OW) != 0)) begin : g_param_check
    $error("sb_rx_serializer: DW must be a non-zero integer multiple of OW");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [NB-1:0][OW-1:0] r_data;
  logic [31:0]           r_dest;
  logic                  r_last;
  logic                  r_out_valid;
  logic                  r_out_first;
  logic                  r_out_last;

  logic                  w_at_end;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic [IW-1:0]         w_idx_nxt;

  // The final beat may hand over to a new packet in the same cycle, so
  // in_ready follows out_ready combinationally there.
  assign w_at_end   = (r_state == ST_BUSY) && (r_idx == LAST_IDX);
  assign in_ready   = (r_state == ST_EMPTY) || (w_at_end && out_ready);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_idx_nxt  = r_idx + IW'(1);

  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;
  assign out_data   = r_data[r_idx];
  assign out_dest   = r_dest;

  // Control FSM: beat index, state and registered beat flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_in_xfer) begin
      // New packet: either from EMPTY or overlapping the last beat.
      r_state     <= ST_BUSY;
      r_idx       <= '0;
      r_last      <= in_last;
      r_out_valid <= 1'b1;
      r_out_first <= 1'b1;
      r_out_last  <= (NB == 1) && in_last;
    end else if (w_out_xfer) begin
      if (w_at_end) begin
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
        r_out_first <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_idx       <= w_idx_nxt;
        r_out_first <= 1'b0;
        r_out_last  <= (w_idx_nxt == LAST_IDX) && r_last;
      end
    end
  end

  // Payload and destination holding registers; contents are don't-care
  // while empty, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_data <= in_data;
      r_dest <= in_dest;
    end
  end

endmodule
`default_nettype wire
